// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer arithmetic for the single-clock flagged FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_ALMOST_FULL_MARGIN = 2;
    localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 2;

    // Occupancy from wrap-bit pointers; result is modulo 2^(addr_width+1).
    function automatic logic [31:0] ptr_count(input logic [31:0] wr_ptr,
                                              input logic [31:0] rd_ptr,
                                              input int unsigned addr_width);
        logic [31:0] mask;
        mask = (32'd1 << (addr_width + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array: registered write port, combinational read port, no reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];

    always_ff @(posedge clock) begin
        if (write_en) mem_q[write_addr] <= write_data;
    end

    assign read_data = mem_q[read_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full-depth capacity, occupancy, threshold and sticky error flags.
// Define SYNC_FIFO_CLEAR_EN to add a synchronous clear input.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 4,
    parameter int ADDRESS_WIDTH      = 5,
    parameter int ALMOST_FULL_LEVEL  = (2**ADDRESS_WIDTH) - DEFAULT_ALMOST_FULL_MARGIN,
    parameter int ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL
) (
    input  logic                     clock,
    input  logic                     reset,
`ifdef SYNC_FIFO_CLEAR_EN
    input  logic                     clear,
`endif
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_valid,
    output logic                     write_ready,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     read_valid,
    input  logic                     read_ready,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0] AF_LVL  = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LVL  = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [ADDRESS_WIDTH:0] write_ptr_q, write_ptr_d;
    logic [ADDRESS_WIDTH:0] read_ptr_q, read_ptr_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   clear_int;
    logic                   push, pop;

`ifdef SYNC_FIFO_CLEAR_EN
    assign clear_int = clear;
`else
    assign clear_int = 1'b0;
`endif

    assign full  = (write_ptr_q[ADDRESS_WIDTH] != read_ptr_q[ADDRESS_WIDTH]) &&
                   (write_ptr_q[ADDRESS_WIDTH-1:0] == read_ptr_q[ADDRESS_WIDTH-1:0]);
    assign empty = (write_ptr_q == read_ptr_q);
    assign count = (ADDRESS_WIDTH+1)'(ptr_count(32'(write_ptr_q), 32'(read_ptr_q), ADDRESS_WIDTH));

    assign write_ready  = ~full;
    assign read_valid   = ~empty;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Handshakes gate on the flags, so a full FIFO never accepts a same-cycle bypass write.
    assign push = write_valid & ~full;
    assign pop  = read_ready & ~empty;

    always_comb begin
        write_ptr_d = write_ptr_q;
        read_ptr_d  = read_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_int) begin
            write_ptr_d = '0;
            read_ptr_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) write_ptr_d = write_ptr_q + PTR_ONE;
            if (pop)  read_ptr_d  = read_ptr_q + PTR_ONE;
            overflow_d  = overflow_q | (write_valid & full);
            underflow_d = underflow_q | (read_ready & empty);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_ptr_q <= '0;
            read_ptr_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            write_ptr_q <= write_ptr_d;
            read_ptr_q  <= read_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_ram (
        .clock     (clock),
        .write_en  (push & ~clear_int),
        .write_addr(write_ptr_q[ADDRESS_WIDTH-1:0]),
        .write_data(write_data),
        .read_addr (read_ptr_q[ADDRESS_WIDTH-1:0]),
        .read_data (read_data)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: accepted pushes queue expected data, a negedge monitor checks pops.
module tb_sync_fifo_flags;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_valid = 1'b0;
    logic          write_ready;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          read_ready = 1'b0;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Bench-side model
    logic [DW-1:0] exp_q[$];
    int  m_cnt = 0;
    bit  m_ovf = 0;
    bit  m_unf = 0;

    sync_fifo_flags dut (
        .clock       (clock),
        .reset       (reset),
`ifdef SYNC_FIFO_CLEAR_EN
        .clear       (clear),
`endif
        .write_data  (write_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a head that is being taken.
    always @(negedge clock) begin
        if (!reset && read_valid === 1'b1 && read_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: read_valid=1 with empty scoreboard at %0t", $time);
            end else begin
                check("read_data", int'(read_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, ".count"},        int'(count),        m_cnt);
        check({tag, ".full"},         int'(full),         int'(m_cnt == DEPTH));
        check({tag, ".empty"},        int'(empty),        int'(m_cnt == 0));
        check({tag, ".write_ready"},  int'(write_ready),  int'(m_cnt != DEPTH));
        check({tag, ".read_valid"},   int'(read_valid),   int'(m_cnt != 0));
        check({tag, ".almost_full"},  int'(almost_full),  int'(m_cnt >= DEPTH - 2));
        check({tag, ".almost_empty"}, int'(almost_empty), int'(m_cnt <= 2));
        check({tag, ".overflow"},     int'(overflow),     int'(m_ovf));
        check({tag, ".underflow"},    int'(underflow),    int'(m_unf));
    endtask

    // Called at posedge+1: apply inputs, update model, advance one edge, check flags.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input string tag);
        bit push, pop;
        write_valid = wv;
        write_data  = wd;
        read_ready  = rr;
        push = wv && (m_cnt != DEPTH);
        pop  = rr && (m_cnt != 0);
        if (wv && m_cnt == DEPTH) m_ovf = 1;
        if (rr && m_cnt == 0)     m_unf = 1;
        if (push) exp_q.push_back(wd);
        m_cnt = m_cnt + int'(push) - int'(pop);
        @(posedge clock); #1;
        write_valid = 1'b0;
        read_ready  = 1'b0;
        check_flags(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_flags("reset");
        step(0, 0, 0, "idle");

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, DW'(i % 16), 0, "fill");
        step(1, 4'hA, 0, "overflow");

        // Drain, then underflow
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, "drain");
        step(0, 0, 1, "underflow");

        // Steady state at count 10 across pointer wraps
        for (int i = 0; i < 10; i++) step(1, DW'(i), 0, "prime10");
        for (int i = 0; i < 100; i++) step(1, DW'((i * 7 + 3) % 16), 1, "steady");

        // Full with push+pop: pop only
        for (int i = 0; i < DEPTH - 10; i++) step(1, DW'(15 - (i % 16)), 0, "refill");
        step(1, 4'h5, 1, "full_pushpop");
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, "drain2");

        // Empty with push+pop: push only
        step(1, 4'h9, 1, "empty_pushpop");
        step(0, 0, 1, "pop_single");

`ifdef SYNC_FIFO_CLEAR_EN
        for (int i = 0; i < 7; i++) step(1, DW'(i + 2), 0, "prime7");
        write_valid = 1'b1;
        write_data  = 4'h3;
        clear       = 1'b1;
        @(posedge clock); #1;
        clear       = 1'b0;
        write_valid = 1'b0;
        m_cnt = 0; m_ovf = 0; m_unf = 0;
        exp_q.delete();
        check_flags("clear");
`endif

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1, DW'(i + 8), 0, "prime5");
        #1 reset = 1'b1;
        #1;
        m_cnt = 0; m_ovf = 0; m_unf = 0;
        exp_q.delete();
        check_flags("async_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        check_flags("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO with a valid/ready handshake on both sides.
- Generalises the team's CDC FIFO for same-domain buffering: full 2^ADDRESS_WIDTH capacity (no sacrificed slot), live occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Sits between producer/consumer blocks sharing one clock; write side and read side are independent handshakes.

Parameters:
- DATA_WIDTH, 4, width of each entry in bits.
- ADDRESS_WIDTH, 5, log2 of depth; DEPTH = 2^ADDRESS_WIDTH entries, all usable.
- ALMOST_FULL_LEVEL, 2^ADDRESS_WIDTH-2, almost_full asserts when count >= this; legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when count <= this; legal range 0..DEPTH-1.

Ports:
- clock  in  1  clock; all state updates on rising edge.
- reset  in  1  reset; asynchronous, active-high.
- write_data  in  DATA_WIDTH  entry to push.
- write_valid  in  1  producer offers write_data.
- write_ready  out  1  FIFO can accept; equals !full.
- read_data  out  DATA_WIDTH  head entry; meaningful only while read_valid.
- read_valid  out  1  head entry present; equals !empty.
- read_ready  in  1  consumer pops head this cycle.
- count  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers: write_ptr, read_ptr, each ADDRESS_WIDTH+1 bits (extra wrap bit). count = write_ptr - read_ptr, modulo 2^(ADDRESS_WIDTH+1).
- full when the MSBs differ and the lower bits are equal; empty when the pointers are equal. Both flags are derived combinationally from the registered pointers.
- Push: write_valid & write_ready at an edge stores write_data at memory[write_ptr[ADDRESS_WIDTH-1:0]] and increments write_ptr.
- Pop: read_valid & read_ready at an edge increments read_ptr.
- read_data = memory[read_ptr[ADDRESS_WIDTH-1:0]], combinational read, no output register.
- Latency: push at edge N gives read_valid=1 and the pushed data on read_data immediately after edge N.
- Simultaneous push and pop, not full and not empty: both occur; count unchanged.
- Full with push+pop in the same cycle: pop only. No bypass, because write_ready is low while full.
- Empty with push+pop in the same cycle: push only.
- Pointer wrap: low bits roll over from DEPTH-1 to 0 and the wrap bit toggles. Ordering is preserved across wraps.
- overflow sets on any edge with write_valid & !write_ready. underflow sets on any edge with read_ready & !read_valid. Both hold until reset.
- Reset values: both pointers 0, count=0, empty=1, read_valid=1'b0, full=0, write_ready=1, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Memory contents are not reset; read_data is don't-care while empty.
- Reset asserted mid-operation: everything returns to reset values asynchronously; all stored entries are discarded.
- No state machine beyond the pointers and sticky flags. All arithmetic is unsigned, modulo 2^(ADDRESS_WIDTH+1).

Optional Feature:
- Macro: SYNC_FIFO_CLEAR_EN.
- Defined: adds input port clear (1 bit, synchronous, active-high).
  - When clear=1 at an edge: both pointers go to 0, and overflow/underflow are cleared.
  - clear has priority over any push/pop in the same cycle; the push is dropped and does not set overflow.
- Undefined: no clear port; the FIFO empties only via pops or reset.

Decomposition:
- Package sync_fifo_pkg holds:
  - a function computing count from two pointers given ADDRESS_WIDTH;
  - localparam defaults for the almost-level parameters.
- One sub-module, sync_fifo_ram: DATA_WIDTH x DEPTH array, registered write port, combinational read port.

Test Plan:
- Reset then idle -> empty=1, read_valid=0, count=0, almost_empty=1, write_ready=1, overflow=0.
- Push 32 values 0x0..0xF,0x0..0xF with read_ready=0 (ADDRESS_WIDTH=5) -> count=32, full=1, write_ready=0, almost_full=1 from count 30; a 33rd write_valid sets overflow=1 and count stays 32.
- Pop all 32 -> data out in push order; empty=1 after the 32nd pop; an extra read_ready sets underflow=1.
- Hold count at 10; drive push+pop every cycle for 100 cycles -> count stays 10, data ordering holds across pointer wrap.
- Full FIFO with push+pop in the same cycle -> count 32→31, pushed word not stored. Empty FIFO with push+pop -> count 0→1, read_valid=1 next cycle.
- With SYNC_FIFO_CLEAR_EN: count=7, overflow=1, pulse clear alongside a push -> count=0, empty=1, overflow=0.
- Reset asserted mid-stream at count=5 -> count=0 asynchronously, before the next edge.
